hazard_scoreboard: RTL

- Hazard unit for the 5-stage MIPS pipeline. It sits directly downstream of the D-stage main decoder and consumes that decoder's per-instruction Tuse/Tnew, destination and source register fields.
- It tracks in-flight producers through E/M/W in its own registered pipeline.
- It generates the F/D freeze, the D/E bubble and the forwarding-mux selects for the D, E and M stages.
- It also counts stall cycles for performance debug.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_fwd_sel.sv | 28 ++
 rtl/hazard_scoreboard.sv | 90 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forward codes, stage-entry type and helpers for the hazard unit
package hazard_pkg;

  localparam logic [1:0] FWD_NONE  = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] A3;
    logic [1:0] Tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;

  // Saturating 2-bit decrement; a ready result stays ready as it moves down the pipe.
  function automatic logic [1:0] dec2(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - newest-first forward select of one register against E/M/W producers
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] reg_i,
  input  logic [4:0] e_a3_i,
  input  logic       e_rdy_i,
  input  logic [4:0] m_a3_i,
  input  logic       m_rdy_i,
  input  logic [4:0] w_a3_i,
  output logic [1:0] fwd_o
);

  // W results are always ready; candidates a reader cannot see are masked via *_rdy_i.
  always_comb begin
    fwd_o = FWD_NONE;
    if (reg_i != 5'd0) begin
      if (e_rdy_i && (e_a3_i == reg_i)) begin
        fwd_o = FWD_E;
      end else if (m_rdy_i && (m_a3_i == reg_i)) begin
        fwd_o = FWD_M;
      end else if (w_a3_i == reg_i) begin
        fwd_o = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - stall/forward unit for the 5-stage MIPS pipeline with stall counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic [4:0]       D_A3,
  input  logic [1:0]       D_Tnew,
  output logic             stall,
  output logic [1:0]       fwd_D_rs,
  output logic [1:0]       fwd_D_rt,
  output logic [1:0]       fwd_E_rs,
  output logic [1:0]       fwd_E_rt,
  output logic [1:0]       fwd_M_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_t           e_q, e_d;
  logic [4:0]       m_a3_q, m_a3_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [4:0]       m_rt_q, m_rt_d;
  logic [4:0]       w_a3_q, w_a3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_rs, stall_rt;
  logic             e_rdy, m_rdy;

  assign stall_rs = (D_rs != 5'd0) && (D_Tuse_rs != TUSE_NONE) &&
                    (((e_q.A3 == D_rs) && (e_q.Tnew > D_Tuse_rs)) ||
                     ((m_a3_q == D_rs) && (m_tnew_q > D_Tuse_rs)));
  assign stall_rt = (D_rt != 5'd0) && (D_Tuse_rt != TUSE_NONE) &&
                    (((e_q.A3 == D_rt) && (e_q.Tnew > D_Tuse_rt)) ||
                     ((m_a3_q == D_rt) && (m_tnew_q > D_Tuse_rt)));
  assign stall     = stall_rs | stall_rt;
  assign stall_cnt = cnt_q;

  assign e_rdy = (e_q.Tnew == 2'd0);
  assign m_rdy = (m_tnew_q == 2'd0);

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.A3   = D_A3;
      e_d.Tnew = dec2(D_Tnew);
      e_d.rs   = D_rs;
      e_d.rt   = D_rt;
    end
    m_a3_d   = e_q.A3;
    m_tnew_d = dec2(e_q.Tnew);
    m_rt_d   = e_q.rt;
    w_a3_d   = m_a3_q;
    cnt_d    = cnt_q + CNT_W'(stall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      m_a3_q   <= '0;
      m_tnew_q <= '0;
      m_rt_q   <= '0;
      w_a3_q   <= '0;
      cnt_q    <= '0;
    end else begin
      e_q      <= e_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      m_rt_q   <= m_rt_d;
      w_a3_q   <= w_a3_d;
      cnt_q    <= cnt_d;
    end
  end

  // Readers in E see only M/W, readers in M see only W.
  hazard_fwd_sel u_fwd_d_rs (.reg_i(D_rs), .e_a3_i(e_q.A3), .e_rdy_i(e_rdy), .m_a3_i(m_a3_q),
                             .m_rdy_i(m_rdy), .w_a3_i(w_a3_q), .fwd_o(fwd_D_rs));
  hazard_fwd_sel u_fwd_d_rt (.reg_i(D_rt), .e_a3_i(e_q.A3), .e_rdy_i(e_rdy), .m_a3_i(m_a3_q),
                             .m_rdy_i(m_rdy), .w_a3_i(w_a3_q), .fwd_o(fwd_D_rt));
  hazard_fwd_sel u_fwd_e_rs (.reg_i(e_q.rs), .e_a3_i(e_q.A3), .e_rdy_i(1'b0), .m_a3_i(m_a3_q),
                             .m_rdy_i(m_rdy), .w_a3_i(w_a3_q), .fwd_o(fwd_E_rs));
  hazard_fwd_sel u_fwd_e_rt (.reg_i(e_q.rt), .e_a3_i(e_q.A3), .e_rdy_i(1'b0), .m_a3_i(m_a3_q),
                             .m_rdy_i(m_rdy), .w_a3_i(w_a3_q), .fwd_o(fwd_E_rt));
  hazard_fwd_sel u_fwd_m_rt (.reg_i(m_rt_q), .e_a3_i(e_q.A3), .e_rdy_i(1'b0), .m_a3_i(m_a3_q),
                             .m_rdy_i(1'b0), .w_a3_i(w_a3_q), .fwd_o(fwd_M_rt));

endmodule
